// File: rtl/peg_l2_mac_tx_arb_pkg.sv
// Shared types for the L2 MAC TX packet arbiter: FSM states, source select
// encoding and default widths.
package peg_l2_mac_tx_arb_pkg;

  localparam int PKT_DATA_W_DEF = 8;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_CTRL = 2'd1,
    ST_GNT_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_CTRL = 1'b0,
    SRC_DATA = 1'b1
  } src_sel_e;

  // Number of beats discarded in one cycle (both sources may drop at once).
  function automatic logic [1:0] drop_inc(input logic ctrl_disc, input logic data_disc);
    return {1'b0, ctrl_disc} + {1'b0, data_disc};
  endfunction

endpackage

// File: rtl/peg_pkt_pipe_reg.sv
// Single-entry valid/ready output register; a new beat may load whenever the
// slot is empty or is being drained in the same cycle.
module peg_pkt_pipe_reg #(
  parameter int PAYLOAD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 load_en
);

  logic                 valid_r;
  logic [PAYLOAD_W-1:0] data_r;

  assign load_en   = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Output slot: load wins over drain so back-to-back beats stream at full rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/peg_l2_mac_tx_arb.sv
// Packet-granular ctrl/data arbiter feeding the MAC TX framer.
// Build option: PEG_L2_MAC_TX_ARB_RR_EN selects round-robin instead of ctrl priority.
module peg_l2_mac_tx_arb
  import peg_l2_mac_tx_arb_pkg::*;
#(
  parameter int PKT_DATA_W = PKT_DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mac_pause_en,
  input  logic                  ctrl_tx_valid,
  input  logic                  ctrl_tx_sop,
  input  logic                  ctrl_tx_eop,
  input  logic [PKT_DATA_W-1:0] ctrl_tx_data,
  output logic                  ctrl_tx_ready,
  input  logic                  data_tx_valid,
  input  logic                  data_tx_sop,
  input  logic                  data_tx_eop,
  input  logic [PKT_DATA_W-1:0] data_tx_data,
  output logic                  data_tx_ready,
  output logic                  llc_tx_valid,
  output logic                  llc_tx_sop,
  output logic                  llc_tx_eop,
  output logic [PKT_DATA_W-1:0] llc_tx_data,
  input  logic                  llc_tx_ready,
  output logic [1:0]            arb_state,
  output logic [CNT_W-1:0]      ctrl_pkt_cnt,
  output logic [CNT_W-1:0]      data_pkt_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  arb_state_e             state_r;
  logic [CNT_W-1:0]       ctrl_cnt_r, data_cnt_r, drop_cnt_r;
  logic                   load_en_s, load_s;
  logic                   ctrl_req_s, data_req_s, ctrl_disc_s, data_disc_s;
  logic                   ctrl_ready_s, data_ready_s, ctrl_acc_s, data_acc_s;
  logic                   pick_ctrl_s, pick_data_s;
  logic [PKT_DATA_W+1:0]  load_payload_s, out_payload_s;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
  src_sel_e               last_grant_r;
`endif

  // Per-state handshake: discard headless beats in IDLE, stream the granted source otherwise.
  always_comb begin
    ctrl_req_s     = ctrl_tx_valid && ctrl_tx_sop;
    data_req_s     = data_tx_valid && data_tx_sop && !mac_pause_en;
    ctrl_disc_s    = 1'b0;
    data_disc_s    = 1'b0;
    ctrl_ready_s   = 1'b0;
    data_ready_s   = 1'b0;
    ctrl_acc_s     = 1'b0;
    data_acc_s     = 1'b0;
    load_s         = 1'b0;
    load_payload_s = '0;
    case (state_r)
      ST_IDLE: begin
        ctrl_disc_s  = ctrl_tx_valid && !ctrl_tx_sop;
        data_disc_s  = data_tx_valid && !data_tx_sop;
        ctrl_ready_s = ctrl_disc_s;
        data_ready_s = data_disc_s;
      end
      ST_GNT_CTRL: begin
        ctrl_ready_s   = load_en_s;
        ctrl_acc_s     = ctrl_tx_valid && load_en_s;
        load_s         = ctrl_acc_s;
        load_payload_s = {ctrl_tx_sop, ctrl_tx_eop, ctrl_tx_data};
      end
      ST_GNT_DATA: begin
        data_ready_s   = load_en_s;
        data_acc_s     = data_tx_valid && load_en_s;
        load_s         = data_acc_s;
        load_payload_s = {data_tx_sop, data_tx_eop, data_tx_data};
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Winner selection among eligible requesters.
  always_comb begin
    pick_ctrl_s = 1'b0;
    pick_data_s = 1'b0;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
    if (ctrl_req_s && data_req_s) begin
      pick_ctrl_s = (last_grant_r == SRC_DATA);
      pick_data_s = (last_grant_r == SRC_CTRL);
    end else begin
      pick_ctrl_s = ctrl_req_s;
      pick_data_s = data_req_s;
    end
`else
    if (ctrl_req_s) begin
      pick_ctrl_s = 1'b1;
    end else begin
      pick_data_s = data_req_s;
    end
`endif
  end

  // FSM, packet counters and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ctrl_cnt_r <= '0;
      data_cnt_r <= '0;
      drop_cnt_r <= '0;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
      last_grant_r <= SRC_DATA;
`endif
    end else begin
      drop_cnt_r <= drop_cnt_r + {{(CNT_W-2){1'b0}}, drop_inc(ctrl_disc_s, data_disc_s)};
      case (state_r)
        ST_IDLE: begin
          if (pick_ctrl_s) begin
            state_r <= ST_GNT_CTRL;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
            last_grant_r <= SRC_CTRL;
`endif
          end else if (pick_data_s) begin
            state_r <= ST_GNT_DATA;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
            last_grant_r <= SRC_DATA;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_CTRL: begin
          if (ctrl_acc_s && ctrl_tx_eop) begin
            state_r    <= ST_IDLE;
            ctrl_cnt_r <= ctrl_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_GNT_CTRL;
          end
        end
        ST_GNT_DATA: begin
          if (data_acc_s && data_tx_eop) begin
            state_r    <= ST_IDLE;
            data_cnt_r <= data_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_GNT_DATA;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  peg_pkt_pipe_reg #(
    .PAYLOAD_W (PKT_DATA_W + 2)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (load_payload_s),
    .out_ready (llc_tx_ready),
    .out_valid (llc_tx_valid),
    .out_data  (out_payload_s),
    .load_en   (load_en_s)
  );

  // Readies are forced low while reset is held so no beat is consumed during reset.
  assign ctrl_tx_ready = ctrl_ready_s && !rst;
  assign data_tx_ready = data_ready_s && !rst;
  assign llc_tx_sop    = out_payload_s[PKT_DATA_W+1];
  assign llc_tx_eop    = out_payload_s[PKT_DATA_W];
  assign llc_tx_data   = out_payload_s[PKT_DATA_W-1:0];
  assign arb_state     = state_r;
  assign ctrl_pkt_cnt  = ctrl_cnt_r;
  assign data_pkt_cnt  = data_cnt_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_peg_l2_mac_tx_arb.sv
// Randomized packet-level bench for peg_l2_mac_tx_arb: source/sink queues plus
// a packet-order scoreboard.
module tb_peg_l2_mac_tx_arb;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mac_pause_en = 1'b0;
  logic ctrl_tx_valid = 1'b0, ctrl_tx_sop = 1'b0, ctrl_tx_eop = 1'b0, ctrl_tx_ready;
  logic data_tx_valid = 1'b0, data_tx_sop = 1'b0, data_tx_eop = 1'b0, data_tx_ready;
  logic [DW-1:0] ctrl_tx_data = '0, data_tx_data = '0, llc_tx_data;
  logic llc_tx_valid, llc_tx_sop, llc_tx_eop;
  logic llc_tx_ready = 1'b0;
  logic [1:0] arb_state;
  logic [CW-1:0] ctrl_pkt_cnt, data_pkt_cnt, drop_cnt;

  peg_l2_mac_tx_arb dut (
    .clk(clk), .rst(rst), .mac_pause_en(mac_pause_en),
    .ctrl_tx_valid(ctrl_tx_valid), .ctrl_tx_sop(ctrl_tx_sop), .ctrl_tx_eop(ctrl_tx_eop),
    .ctrl_tx_data(ctrl_tx_data), .ctrl_tx_ready(ctrl_tx_ready),
    .data_tx_valid(data_tx_valid), .data_tx_sop(data_tx_sop), .data_tx_eop(data_tx_eop),
    .data_tx_data(data_tx_data), .data_tx_ready(data_tx_ready),
    .llc_tx_valid(llc_tx_valid), .llc_tx_sop(llc_tx_sop), .llc_tx_eop(llc_tx_eop),
    .llc_tx_data(llc_tx_data), .llc_tx_ready(llc_tx_ready),
    .arb_state(arb_state), .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic sop; logic eop; logic [DW-1:0] data;} beat_t;

  beat_t cq[$], dq[$], ce[$], de[$], outq[$];
  int    out_cyc[$], sop_cyc[$], eop_cyc[$];
  int    cyc = 0, checks = 0, failures = 0;
  int    rdy_mode = 0, gap_pct = 0;
  bit    pause_v = 1'b0, pause_rand = 1'b0, chk_stall = 1'b0, eop_prev = 1'b0;
  bit    s_drdy, s_llcv;
  int    exp_ccnt = 0, exp_dcnt = 0, exp_drop = 0;

  // Data MSB tags the source: 0 = ctrl, 1 = data.
  task automatic add_pkt(input bit is_data, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      b.data = {is_data, 7'($urandom)};
      if (is_data) begin dq.push_back(b); de.push_back(b); end
      else begin cq.push_back(b); ce.push_back(b); end
    end
    if (is_data) exp_dcnt++; else exp_ccnt++;
  endtask

  task automatic step();
    bit cv, dv, ca, da, lv;
    beat_t ob;
    @(negedge clk);
    cyc++;
    cv = (cq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    dv = (dq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    ctrl_tx_valid = cv;
    {ctrl_tx_sop, ctrl_tx_eop, ctrl_tx_data} = cv ? cq[0] : '0;
    data_tx_valid = dv;
    {data_tx_sop, data_tx_eop, data_tx_data} = dv ? dq[0] : '0;
    case (rdy_mode)
      0: llc_tx_ready = 1'b1;
      1: llc_tx_ready = cyc[0];
      default: llc_tx_ready = 1'($urandom_range(0, 1));
    endcase
    mac_pause_en = pause_rand ? ($urandom_range(0, 2) == 0) : pause_v;
    #1;
    ca = ctrl_tx_valid && ctrl_tx_ready;
    da = data_tx_valid && data_tx_ready;
    s_drdy = data_tx_ready;
    s_llcv = llc_tx_valid;
    if (chk_stall && llc_tx_valid && !llc_tx_ready) begin
      checks++;
      if (ctrl_tx_ready || data_tx_ready) begin
        failures++;
        $display("FAIL stall_ready: ctrl_rdy=%0b data_rdy=%0b required 0 while output stalled at cycle %0d",
                 ctrl_tx_ready, data_tx_ready, cyc);
      end
    end
    if ((ca && ctrl_tx_sop) || (da && data_tx_sop)) begin
      sop_cyc.push_back(cyc);
      checks++;
      if (eop_prev) begin
        failures++;
        $display("FAIL dead_cycle: sop accepted at cycle %0d directly after an eop, required one idle cycle", cyc);
      end
    end
    eop_prev = (ca && ctrl_tx_eop) || (da && data_tx_eop);
    if (eop_prev) eop_cyc.push_back(cyc);
    lv = llc_tx_valid && llc_tx_ready;
    ob = '{llc_tx_sop, llc_tx_eop, llc_tx_data};
    @(posedge clk);
    if (ca) void'(cq.pop_front());
    if (da) void'(dq.pop_front());
    if (lv) begin outq.push_back(ob); out_cyc.push_back(cyc); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cq.delete(); dq.delete(); ce.delete(); de.delete(); outq.delete();
    out_cyc.delete(); sop_cyc.delete(); eop_cyc.delete();
    exp_ccnt = 0; exp_dcnt = 0; exp_drop = 0;
    rdy_mode = 0; gap_pct = 0; pause_v = 1'b0; pause_rand = 1'b0; chk_stall = 1'b0;
    eop_prev = 1'b0;
    repeat (2) step();
    #2 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((cq.size() > 0 || dq.size() > 0) && n < 3000) begin step(); n++; end
    pause_rand = 1'b0; rdy_mode = 0; gap_pct = 0;
    repeat (4) step();
    checks++;
    if (cq.size() > 0 || dq.size() > 0) begin
      failures++;
      $display("FAIL %s_timeout: ctrl_left=%0d data_left=%0d required 0", name, cq.size(), dq.size());
    end
  endtask

  // Every output packet must equal, beat for beat, the next packet of its source.
  task automatic check_stream(input string name);
    beat_t b, e;
    bit cur = 1'b0;
    foreach (outq[i]) begin
      b = outq[i];
      if (b.sop) cur = b.data[DW-1];
      checks++;
      if (b.data[DW-1] != cur) begin
        failures++;
        $display("FAIL %s_switch: beat %0d source=%0b required %0b", name, i, b.data[DW-1], cur);
      end
      if ((b.data[DW-1] ? de.size() : ce.size()) == 0) begin
        failures++;
        $display("FAIL %s_extra: beat %0d data=%h has no expected beat", name, i, b);
      end else begin
        e = b.data[DW-1] ? de.pop_front() : ce.pop_front();
        if (b !== e) begin
          failures++;
          $display("FAIL %s_beat: beat %0d got=%h required=%h", name, i, b, e);
        end
      end
    end
    checks++;
    if (ce.size() > 0 || de.size() > 0) begin
      failures++;
      $display("FAIL %s_lost: ctrl_missing=%0d data_missing=%0d required 0", name, ce.size(), de.size());
    end
    checks++;
    if (ctrl_pkt_cnt !== 16'(exp_ccnt) || data_pkt_cnt !== 16'(exp_dcnt) || drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL %s_cnt: ctrl=%0d data=%0d drop=%0d required %0d %0d %0d", name,
               ctrl_pkt_cnt, data_pkt_cnt, drop_cnt, exp_ccnt, exp_dcnt, exp_drop);
    end
    outq.delete(); out_cyc.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({llc_tx_valid, llc_tx_sop, llc_tx_eop, llc_tx_data, arb_state, ctrl_tx_ready, data_tx_ready} !== '0 ||
        {ctrl_pkt_cnt, data_pkt_cnt, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL %s: llc v/s/e/d=%0b%0b%0b/%h state=%0d rdy=%0b%0b cnt=%0d/%0d/%0d required all 0", name,
               llc_tx_valid, llc_tx_sop, llc_tx_eop, llc_tx_data, arb_state, ctrl_tx_ready, data_tx_ready,
               ctrl_pkt_cnt, data_pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_ctrl_pkt();
    int t0;
    do_reset();
    add_pkt(1'b0, 4);
    t0 = cyc + 1;
    drain("ctrl_pkt");
    checks++;
    if (out_cyc.size() != 4 || out_cyc[0] != t0 + 2 || out_cyc[3] != t0 + 5) begin
      failures++;
      $display("FAIL ctrl_pkt_timing: beats=%0d first=%0d last=%0d required 4 %0d %0d",
               out_cyc.size(), out_cyc.size() > 0 ? out_cyc[0] : -1,
               out_cyc.size() > 3 ? out_cyc[3] : -1, t0 + 2, t0 + 5);
    end
    check_stream("ctrl_pkt");
  endtask

  task automatic test_tie();
    bit exp_src[3];
    bit got;
    int k = 0;
`ifdef PEG_L2_MAC_TX_ARB_RR_EN
    exp_src = '{1'b0, 1'b1, 1'b0};
`else
    exp_src = '{1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    add_pkt(1'b0, 2); add_pkt(1'b1, 2); add_pkt(1'b0, 2);
    drain("tie");
    foreach (outq[i]) begin
      if (outq[i].sop) begin
        got = outq[i].data[DW-1];
        checks++;
        if (k > 2 || got != exp_src[k]) begin
          failures++;
          $display("FAIL tie_order: packet %0d source=%0b required %0b", k, got, k > 2 ? 1'b0 : exp_src[k]);
        end
        k++;
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (sop_cyc.size() != 3 || eop_cyc.size() != 3 || sop_cyc[i] != eop_cyc[i-1] + 2) begin
        failures++;
        $display("FAIL tie_gap: packet %0d sop/eop records %0d/%0d, required sop two cycles after previous eop",
                 i, sop_cyc.size(), eop_cyc.size());
      end
    end
    check_stream("tie");
  endtask

  task automatic test_pause();
    do_reset();
    pause_v = 1'b1;
    add_pkt(1'b1, 3);
    repeat (4) begin
      step();
      checks++;
      if (s_drdy !== 1'b0 || s_llcv !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold: data_rdy=%0b llc_valid=%0b required 0 0", s_drdy, s_llcv);
      end
    end
    pause_v = 1'b0;
    step();
    checks++;
    if (s_drdy !== 1'b0) begin
      failures++;
      $display("FAIL pause_release_idle: data_rdy=%0b required 0", s_drdy);
    end
    step();
    checks++;
    if (s_drdy !== 1'b1) begin
      failures++;
      $display("FAIL pause_release_grant: data_rdy=%0b required 1", s_drdy);
    end
    pause_v = 1'b1;
    drain("pause");
    pause_v = 1'b0;
    check_stream("pause");
  endtask

  task automatic test_discard();
    beat_t b;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = '{1'b0, 1'b0, {1'b1, 7'($urandom)}};
      dq.push_back(b);
    end
    exp_drop = 3;
    repeat (3) begin
      step();
      checks++;
      if (s_drdy !== 1'b1) begin
        failures++;
        $display("FAIL discard_ready: data_rdy=%0b required 1", s_drdy);
      end
    end
    drain("discard");
    checks++;
    if (outq.size() != 0) begin
      failures++;
      $display("FAIL discard_out: llc beats=%0d required 0", outq.size());
    end
    check_stream("discard");
  endtask

  task automatic test_toggle();
    do_reset();
    rdy_mode = 1;
    chk_stall = 1'b1;
    add_pkt(1'b0, 6);
    add_pkt(1'b1, 6);
    while (cq.size() > 0 || dq.size() > 0) begin
      if (cyc > 90000) break;
      step();
      rdy_mode = 1;
    end
    drain("toggle");
    checks++;
    if (outq.size() != 12) begin
      failures++;
      $display("FAIL toggle_count: llc beats=%0d required 12", outq.size());
    end
    check_stream("toggle");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      rdy_mode = 2; pause_rand = 1'b1; gap_pct = 20; chk_stall = 1'b1;
      repeat ($urandom_range(1, 3)) add_pkt(1'b0, $urandom_range(1, 5));
      repeat ($urandom_range(1, 3)) add_pkt(1'b1, $urandom_range(1, 5));
      drain("random");
      check_stream("random");
    end
    chk_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    add_pkt(1'b1, 6);
    repeat (3) step();
    checks++;
    if (s_llcv !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: llc_valid=%0b required 1 before reset", s_llcv);
    end
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    do_reset();
    add_pkt(1'b0, 2);
    drain("after_rst");
    check_stream("after_rst");
  endtask

  initial begin
    test_reset();
    test_ctrl_pkt();
    test_tie();
    test_pause();
    test_discard();
    test_toggle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
